irs_pedestal_scan_controller: RTL and testbench

Sequences a pedestal scan over a range of IRS storage blocks by driving the block manager's pedestal-mode inputs (`ped_mode`, `ped_address`, `ped_sample`). For each block it forces a single write, waits for the write controller's block acknowledge, and then hands the block to readout through a request/acknowledge handshake. It repeats this a programmable number of times per block before advancing. It sits between the run-control registers and the block manager's `ped_*` inputs.

---
 rtl/irs_pedestal_scan_controller.sv | 130 +++++++++++++
 tb/tb_irs_pedestal_scan_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/irs_pedestal_scan_controller.sv
// Pedestal scan sequencer: drives the block manager's ped_* inputs one block at a time,
// forcing a write per sample and passing each written block to readout by req/ack.
module irs_pedestal_scan_controller #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT   = 4095
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [8:0] first_blk_i,
  input  logic [8:0] last_blk_i,
  input  logic [7:0] repeat_i,
  input  logic       blk_ack_i,
  input  logic       rd_ack_i,
  output logic       ped_mode_o,
  output logic [8:0] ped_address_o,
  output logic       ped_sample_o,
  output logic       rd_req_o,
  output logic [8:0] rd_blk_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LIMIT    = TW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_WAIT_ACK, S_READ, S_NEXT, S_FINISH
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [8:0]      r_last;
  logic [8:0]      r_addr;
  logic [7:0]      r_rep;
  logic [7:0]      r_rep_cnt;
  logic [SW-1:0]   r_set_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic            r_abort_pend;
  logic            w_abort;
  logic [TW-1:0]   w_to_nxt;
  logic            w_to_expire;

  assign w_abort       = abort_i | r_abort_pend;
  assign w_to_nxt      = r_to_cnt + 1'b1;
  assign w_to_expire   = (w_to_nxt == TO_LIMIT);
  assign ped_address_o = r_addr;
  assign rd_blk_o      = r_addr;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start_i) w_nxt = S_SETTLE;
      S_SETTLE:   if (w_abort) w_nxt = S_FINISH;
                  else if (r_set_cnt == SETTLE_LAST) w_nxt = S_SAMPLE;
      S_SAMPLE:   w_nxt = w_abort ? S_FINISH : S_WAIT_ACK;
      S_WAIT_ACK: if (w_abort) w_nxt = S_FINISH;
                  else if (blk_ack_i) w_nxt = S_READ;
                  else if (w_to_expire) w_nxt = S_FINISH;
      S_READ:     if (rd_ack_i) begin
                    if (w_abort) w_nxt = S_FINISH;
                    else if (r_rep_cnt != r_rep) w_nxt = S_SAMPLE;
                    else if (r_addr == r_last) w_nxt = S_FINISH;
                    else w_nxt = S_NEXT;
                  end
      S_NEXT:     w_nxt = w_abort ? S_FINISH : S_SAMPLE;
      S_FINISH:   w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_last       <= '0;
      r_addr       <= '0;
      r_rep        <= '0;
      r_rep_cnt    <= '0;
      r_set_cnt    <= '0;
      r_to_cnt     <= '0;
      r_abort_pend <= 1'b0;
      ped_mode_o   <= 1'b0;
      ped_sample_o <= 1'b0;
      rd_req_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      // Outputs are registered from the next state so they line up with it.
      ped_mode_o   <= (w_nxt != S_IDLE) && (w_nxt != S_FINISH);
      busy_o       <= (w_nxt != S_IDLE);
      ped_sample_o <= (w_nxt == S_SAMPLE);
      rd_req_o     <= (w_nxt == S_READ);
      done_o       <= (r_state == S_FINISH);

      if ((r_state == S_IDLE) || (r_state == S_FINISH)) r_abort_pend <= 1'b0;
      else if (abort_i) r_abort_pend <= 1'b1;

      case (r_state)
        S_IDLE: if (start_i) begin
          r_last    <= last_blk_i;
          r_rep     <= repeat_i;
          r_addr    <= first_blk_i;
          r_rep_cnt <= '0;
          r_set_cnt <= '0;
          err_o     <= 1'b0;
        end
        S_SETTLE:   r_set_cnt <= r_set_cnt + 1'b1;
        S_SAMPLE:   r_to_cnt <= '0;
        S_WAIT_ACK: begin
          r_to_cnt <= w_to_nxt;
          if (!w_abort && !blk_ack_i && w_to_expire) err_o <= 1'b1;
        end
        S_READ: begin
          if (w_nxt == S_SAMPLE) r_rep_cnt <= r_rep_cnt + 1'b1;
          // Advance on entry to NEXT so the new address is stable a cycle before its sample.
          if (w_nxt == S_NEXT) begin
            r_addr    <= r_addr + 1'b1;
            r_rep_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_irs_pedestal_scan_controller.sv
// Bench for irs_pedestal_scan_controller: a timeline model predicts every sample,
// readout window, busy/mode/done/err span; a per-cycle compare checks the DUT against it.
module tb_irs_pedestal_scan_controller;
  localparam int unsigned S     = 4;
  localparam int unsigned T     = 15;
  localparam int unsigned NEVER = 32'hFFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst_i, start_i, abort_i, blk_ack_i, rd_ack_i;
  logic [8:0] first_blk_i, last_blk_i;
  logic [7:0] repeat_i;
  logic       ped_mode_o, ped_sample_o, rd_req_o, busy_o, done_o, err_o;
  logic [8:0] ped_address_o, rd_blk_o;

  irs_pedestal_scan_controller #(.SETTLE_CYCLES(S), .ACK_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .first_blk_i(first_blk_i), .last_blk_i(last_blk_i), .repeat_i(repeat_i),
    .blk_ack_i(blk_ack_i), .rd_ack_i(rd_ack_i),
    .ped_mode_o(ped_mode_o), .ped_address_o(ped_address_o), .ped_sample_o(ped_sample_o),
    .rd_req_o(rd_req_o), .rd_blk_o(rd_blk_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk = 0, n_pass = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // Expected timeline: edges are numbered by cyc as seen on the following negedge.
  typedef struct { int unsigned cyc; int unsigned blk; } samp_t;
  typedef struct { int unsigned rise; int unsigned fall; int unsigned blk; } win_t;
  samp_t       sq[$];
  win_t        wq[$];
  int unsigned m_start = NEVER, m_done = 0, m_err_set = NEVER, m_err_clr = NEVER;
  bit          chk_en = 0;

  task automatic plan(input int unsigned first, last, rep, ackd, rdd, k, max_reads,
                      input bit no_ack);
    int unsigned t, b, e, reads;
    bit fin;
    sq.delete(); wq.delete();
    m_start = k;
    if (m_err_set != NEVER && m_err_clr == NEVER) m_err_clr = k;
    t = k + S; b = first; reads = 0; fin = 0;
    while (!fin) begin
      for (int unsigned r = 0; r <= rep && !fin; r++) begin
        sq.push_back('{t, b});
        if (no_ack) begin
          m_err_set = t + 1 + T; m_err_clr = NEVER; m_done = t + 2 + T; fin = 1;
        end else begin
          e = t + ackd + rdd;
          wq.push_back('{t + ackd, e, b});
          reads++;
          if (reads == max_reads || (r == rep && b == last)) begin
            m_done = e + 1; fin = 1;
          end else if (r < rep) t = e;
          else begin t = e + 1; b = (b + 1) % 512; end
        end
      end
    end
  endtask

  // Block-manager / readout responder.
  int unsigned ack_dly = 2, rd_dly = 1, ack_cnt = 0, rd_cnt = 0;
  bit          ack_en = 1, rsp_rd_prev = 0;
  initial begin
    blk_ack_i = 0; rd_ack_i = 0;
    forever begin
      @(negedge clk);
      blk_ack_i = 0; rd_ack_i = 0;
      if (ack_cnt > 0) begin ack_cnt--; if (ack_cnt == 0) blk_ack_i = 1; end
      if (ped_sample_o && ack_en) ack_cnt = ack_dly - 1;
      if (rd_cnt > 0) begin rd_cnt--; if (rd_cnt == 0) rd_ack_i = 1; end
      if (rd_req_o && !rsp_rd_prev) begin
        if (rd_dly == 1) rd_ack_i = 1; else rd_cnt = rd_dly - 1;
      end
      rsp_rd_prev = rd_req_o;
    end
  end

  // Per-cycle compare and observation counters.
  int unsigned n_samp = 0, n_rise = 0, obs_done = 0, obs_err = 0;
  bit          seen [512];
  bit          c_exp_s, c_exp_r, c_rd_prev = 0, c_err_prev = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (ped_sample_o) n_samp++;
      if (rd_req_o && !c_rd_prev) begin n_rise++; seen[rd_blk_o] = 1; end
      if (done_o) obs_done = cyc;
      if (err_o && !c_err_prev) obs_err = cyc;
      c_rd_prev = rd_req_o; c_err_prev = err_o;
      if (chk_en) begin
        c_exp_s = (sq.size() > 0) && (sq[0].cyc == cyc);
        check("ped_sample", ped_sample_o, c_exp_s);
        if (c_exp_s) begin
          check("sample_addr", ped_address_o, sq[0].blk);
          void'(sq.pop_front());
        end
        while (wq.size() > 0 && wq[0].fall <= cyc) void'(wq.pop_front());
        c_exp_r = (wq.size() > 0) && (wq[0].rise <= cyc);
        check("rd_req", rd_req_o, c_exp_r);
        if (c_exp_r) check("rd_blk", rd_blk_o, wq[0].blk);
        check("rd_blk_eq_addr", rd_blk_o, ped_address_o);
        check("busy", busy_o, (cyc >= m_start) && (cyc < m_done));
        check("ped_mode", ped_mode_o, (cyc >= m_start) && (cyc + 1 < m_done));
        check("done", done_o, cyc == m_done);
        check("err", err_o, (cyc >= m_err_set) && (cyc < m_err_clr));
      end
    end
  end

  task automatic run_scan(input int unsigned first, last, rep, ackd, rdd, maxr,
                          input bit noack, abort_start, restart, abort_read,
                          output int unsigned k);
    int unsigned w;
    @(negedge clk);
    first_blk_i = 9'(first); last_blk_i = 9'(last); repeat_i = 8'(rep);
    ack_dly = ackd; rd_dly = rdd; ack_en = !noack;
    k = cyc + 1;
    plan(first, last, rep, ackd, rdd, k, maxr, noack);
    start_i = 1; abort_i = abort_start;
    @(negedge clk);
    start_i = 0; abort_i = 0;
    if (restart) begin
      first_blk_i = 9'd300; last_blk_i = 9'd301; repeat_i = 8'd5; start_i = 1;
      @(negedge clk);
      start_i = 0;
    end
    if (abort_read) begin
      w = 0;
      while (!rd_req_o && w < 100) begin @(negedge clk); w++; end
      check("abort_wait_rdreq", rd_req_o, 1);
      abort_i = 1;
      @(negedge clk);
      abort_i = 0;
    end
    while (cyc < m_done + 2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, s0, r0, w, distinct;
    rst_i = 1; start_i = 0; abort_i = 0;
    first_blk_i = '0; last_blk_i = '0; repeat_i = '0;
    repeat (3) @(negedge clk);
    check("rst_mode", ped_mode_o, 0);   check("rst_sample", ped_sample_o, 0);
    check("rst_rdreq", rd_req_o, 0);    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);       check("rst_err", err_o, 0);
    check("rst_addr", ped_address_o, 0); check("rst_rdblk", rd_blk_o, 0);
    rst_i = 0; chk_en = 1;

    s0 = n_samp;
    run_scan(5, 5, 0, 10, 3, NEVER, 0, 0, 0, 0, k);
    check("single_done_lat", obs_done - k, 18);
    check("single_nsamp", n_samp - s0, 1);
    check("single_addr_idle", ped_address_o, 5);

    s0 = n_samp;
    run_scan(510, 1, 2, 2, 1, NEVER, 0, 0, 0, 0, k);
    check("wrap_nsamp", n_samp - s0, 12);
    check("wrap_done_lat", obs_done - k, 44);
    check("wrap_addr_idle", ped_address_o, 1);

    r0 = n_rise;
    run_scan(40, 41, 0, 2, 1, NEVER, 1, 0, 0, 0, k);
    check("to_err_lat", obs_err - k, 20);
    check("to_done_lat", obs_done - k, 21);
    check("to_no_rdreq", n_rise - r0, 0);
    check("to_err_sticky", err_o, 1);

    s0 = n_samp;
    run_scan(7, 7, 1, 3, 2, NEVER, 0, 1, 1, 0, k);
    check("restart_nsamp", n_samp - s0, 2);
    check("restart_done_lat", obs_done - k, 15);
    check("restart_addr", ped_address_o, 7);
    check("restart_err_clr", err_o, 0);

    s0 = n_samp;
    run_scan(20, 22, 0, 2, 20, 1, 0, 0, 0, 1, k);
    check("abort_nsamp", n_samp - s0, 1);
    check("abort_done_lat", obs_done - k, 27);
    check("abort_addr", ped_address_o, 20);

    for (int i = 0; i < 512; i++) seen[i] = 0;
    run_scan(100, 99, 0, 2, 1, NEVER, 0, 0, 0, 0, k);
    distinct = 0;
    for (int i = 0; i < 512; i++) distinct += seen[i];
    check("full_distinct", distinct, 512);
    check("full_done_lat", obs_done - k, 2052);
    check("full_addr_idle", ped_address_o, 99);

    chk_en = 0;
    @(negedge clk);
    first_blk_i = 9'd10; last_blk_i = 9'd10; repeat_i = '0; ack_en = 0; start_i = 1;
    @(negedge clk);
    start_i = 0;
    w = 0;
    while (!ped_sample_o && w < 50) begin @(negedge clk); w++; end
    check("rstmid_wait_sample", ped_sample_o, 1);
    repeat (3) @(negedge clk);
    check("rstmid_busy_before", busy_o, 1);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    check("rstmid_mode", ped_mode_o, 0);   check("rstmid_busy", busy_o, 0);
    check("rstmid_sample", ped_sample_o, 0); check("rstmid_rdreq", rd_req_o, 0);
    check("rstmid_done", done_o, 0);       check("rstmid_err", err_o, 0);
    check("rstmid_addr", ped_address_o, 0); check("rstmid_rdblk", rd_blk_o, 0);
    repeat (4) begin
      @(negedge clk);
      check("rstmid_no_done", done_o, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
